pix_stream_sched: RTL and testbench
===================================

PIX_STREAM_SCHED -- requirements
Module: pix_stream_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, word-FIFO entries (power of 2).
REQ-002 SHALL have parameter AF_LEVEL, default 12, fill level at which nios_ready deasserts.
REQ-003 SHALL have parameter PIX_PER_FRAME, default 307200, pixels per frame (640x480).
REQ-004 SHALL have port clk  in  1  single system clock, all logic rising-edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port nios_data  in  32  word from Nios PIO: [11:0] pixel A, [23:12] pixel B, [24] SOF marker, [31:25] ignored.
REQ-007 SHALL have port nios_new_pix  in  1  toggle strobe; each level change = one new word.
REQ-008 SHALL have port nios_ready  out  1  high while fill level < AF_LEVEL.
REQ-009 SHALL have port frame_start  in  1  one-cycle pulse from VGA timing at start of frame.
REQ-010 SHALL have port pix_req  in  1  one-cycle pulse per active-area pixel.
REQ-011 SHALL have port pix_out  out  12  RGB444 pixel {r,g,b}.
REQ-012 SHALL have port pix_valid  out  1  pix_out qualifier.
REQ-013 SHALL have port clr_status  in  1  clears sticky flags.
REQ-014 SHALL have port underflow, overflow  out  1 each  sticky error flags.
REQ-015 SHALL have port state  out  2  SEEK=0, ARMED=1, STREAM=2.
REQ-016 SHALL have port fifo_level  out  log2(FIFO_DEPTH)+1  current word count.

Function
REQ-017 SHALL register nios_new_pix into prev every cycle; push nios_data when nios_new_pix != prev.
REQ-018 Push into full FIFO SHALL drop the word and set overflow; level unchanged.
REQ-019 Push and pop in same cycle SHALL both occur; level unchanged (pop-from-empty excluded).
REQ-020 fifo_level SHALL reflect a push/pop in the cycle after the triggering edge.
REQ-021 SEEK: each cycle head word has [24]=0, SHALL pop and discard it; head [24]=1 -> ARMED; empty -> stay.
REQ-022 ARMED: on frame_start -> STREAM, pixel counter=0, half-select=A; pix_req in that cycle ignored (no pix_valid).
REQ-023 STREAM: pix_req with FIFO non-empty SHALL output head pixel A (half=A) or B (half=B) with pix_valid high exactly one cycle later; pop after B.
REQ-024 STREAM: pix_req with FIFO empty SHALL output pix_out=0, pix_valid=1 next cycle, set underflow, increment counter, keep half-select.
REQ-025 Pixel counter SHALL increment per serviced pix_req; at PIX_PER_FRAME-th pixel -> SEEK, half=A.
REQ-026 STREAM + frame_start before count complete SHALL -> SEEK (resync), counter=0, half=A; pix_req same cycle ignored.
REQ-027 pix_valid SHALL be 0 except the cycle after a serviced pix_req; pix_out SHALL hold last value otherwise.
REQ-028 clr_status SHALL clear underflow/overflow; a set event in the same cycle SHALL win.
REQ-029 SOF bit SHALL be ignored while in STREAM (word consumed as normal pixels).

Reset
REQ-030 reset SHALL asynchronously force: state=SEEK, FIFO empty (level 0), prev=0, counter=0, half=A, pix_out=0, pix_valid=0, underflow=0, overflow=0, nios_ready=1.
REQ-031 reset mid-STREAM SHALL discard all buffered words; after release, state=SEEK.

Verification
REQ-032 Push words 0x0000_0ABC, 0x0100_1234 (toggles), then frame_start -> first discarded, state ARMED then STREAM; pix_req x2 -> pix_out 0x234 then 0x001, pix_valid one cycle after each.
REQ-033 Toggle 17 times with FIFO_DEPTH=16, no pops -> level 16, overflow=1, nios_ready=0 from level 12.
REQ-034 STREAM, FIFO empty, pix_req -> pix_out=0, pix_valid=1, underflow=1; clr_status -> underflow=0.
REQ-035 PIX_PER_FRAME=4, two SOF words preloaded, frame_start + 4 pix_req -> state SEEK after 4th, second SOF word -> ARMED.
REQ-036 frame_start at pixel 2 of 4 -> state SEEK, counter 0; simultaneous push+pop at level 5 -> level stays 5.
REQ-037 Assert reset during STREAM with level 7 -> immediately level 0, state SEEK, pix_valid 0, flags 0.

Source files
------------

// File: rtl/pix_stream_sched.sv
// Pixel stream scheduler: buffers two-pixel words from the Nios PIO in a
// small FIFO. It aligns to the start-of-frame marker and then hands out one
// RGB444 pixel per VGA pixel request.
//
// state  | meaning
// SEEK   | discard words until the head word carries the SOF marker
// ARMED  | SOF word at head, waiting for frame_start from VGA timing
// STREAM | serving pix_req from the FIFO, counting pixels in the frame
module pix_stream_sched #(
  parameter int FIFO_DEPTH    = 16,
  parameter int AF_LEVEL      = 12,
  parameter int PIX_PER_FRAME = 307200
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   nios_data,
  input  logic                          nios_new_pix,
  output logic                          nios_ready,
  input  logic                          frame_start,
  input  logic                          pix_req,
  output logic [11:0]                   pix_out,
  output logic                          pix_valid,
  input  logic                          clr_status,
  output logic                          underflow,
  output logic                          overflow,
  output logic [1:0]                    state,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LVL_AF   = (AW+1)'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_LAST = CW'(PIX_PER_FRAME - 1);

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2
  } st_t;

  st_t            st;
  logic [31:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    level;
  logic           prev;
  logic [CW-1:0]  pix_cnt;
  logic           half_b;

  logic        full, empty, push, push_ok, pop, serviced;
  logic [31:0] head;

  assign full     = (level == LVL_FULL);
  assign empty    = (level == '0);
  assign head     = mem[rd_ptr];
  assign push     = (nios_new_pix != prev);
  assign push_ok  = push && !full;
  // frame_start takes priority over a coincident pix_req while streaming
  assign serviced = (st == STREAM) && pix_req && !frame_start;
  assign pop      = ((st == SEEK) && !empty && !head[24]) ||
                    (serviced && !empty && half_b);

  assign nios_ready = (level < LVL_AF);
  assign fifo_level = level;
  assign state      = st;

  // FIFO storage: written only on an accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= nios_data;
  end

  // FIFO pointers, fill level and toggle-edge detector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      prev <= nios_new_pix;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      level <= level + 1'b1;
      else if (pop && !push_ok) level <= level - 1'b1;
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full)      overflow <= 1'b1;
      else if (clr_status)   overflow <= 1'b0;
      if (serviced && empty) underflow <= 1'b1;
      else if (clr_status)   underflow <= 1'b0;
    end
  end

  // Frame alignment FSM and registered pixel output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= SEEK;
      pix_cnt   <= '0;
      half_b    <= 1'b0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= 1'b0;
      case (st)
        SEEK: begin
          if (!empty && head[24]) st <= ARMED;
        end
        ARMED: begin
          if (frame_start) begin
            st      <= STREAM;
            pix_cnt <= '0;
            half_b  <= 1'b0;
          end
        end
        STREAM: begin
          if (frame_start) begin
            st      <= SEEK;
            pix_cnt <= '0;
            half_b  <= 1'b0;
          end else if (pix_req) begin
            pix_valid <= 1'b1;
            if (empty) begin
              pix_out <= '0;
            end else begin
              pix_out <= half_b ? head[23:12] : head[11:0];
              half_b  <= ~half_b;
            end
            if (pix_cnt == CNT_LAST) begin
              st      <= SEEK;
              pix_cnt <= '0;
              half_b  <= 1'b0;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        default: st <= SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_pix_stream_sched.sv
// Directed bench for pix_stream_sched with a 4-pixel frame.
module tb_pix_stream_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] nios_data = '0;
  logic        nios_new_pix = 1'b0;
  logic        nios_ready;
  logic        frame_start = 1'b0;
  logic        pix_req = 1'b0;
  logic [11:0] pix_out;
  logic        pix_valid;
  logic        clr_status = 1'b0;
  logic        underflow, overflow;
  logic [1:0]  state;
  logic [4:0]  fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  pix_stream_sched #(.FIFO_DEPTH(16), .AF_LEVEL(12), .PIX_PER_FRAME(4)) dut (
    .clk(clk), .reset(reset), .nios_data(nios_data), .nios_new_pix(nios_new_pix),
    .nios_ready(nios_ready), .frame_start(frame_start), .pix_req(pix_req),
    .pix_out(pix_out), .pix_valid(pix_valid), .clr_status(clr_status),
    .underflow(underflow), .overflow(overflow), .state(state), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; returns 1 ns after the active edge
  task automatic drive(input logic fs, input logic pr, input logic tg,
                       input logic [31:0] d, input logic clr);
    @(negedge clk);
    frame_start = fs;
    pix_req     = pr;
    clr_status  = clr;
    nios_data   = d;
    if (tg) nios_new_pix = ~nios_new_pix;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    pix_req     = 1'b0;
    clr_status  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", state); end
    n_tests++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
    n_tests++; if (pix_valid !== 1'b0 || pix_out !== 12'h000) begin n_fail++; $display("FAIL rst_pix got %b/%h exp 0/000", pix_valid, pix_out); end
    n_tests++; if (underflow !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rst_flags got %b%b exp 00", underflow, overflow); end
    n_tests++; if (nios_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", nios_ready); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_align_stream;
    drive(0, 0, 1, 32'h0000_0ABC, 0);
    n_tests++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL al_lvl1 got %0d exp 1", fifo_level); end
    drive(0, 0, 1, 32'h0100_1234, 0);
    n_tests++; if (fifo_level !== 5'd1 || state !== 2'd0) begin n_fail++; $display("FAIL al_discard got lvl %0d st %0d exp 1/0", fifo_level, state); end
    drive(0, 0, 0, 32'h0, 0);
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL al_armed got %0d exp 1", state); end
    drive(1, 0, 0, 32'h0, 0);
    n_tests++; if (state !== 2'd2 || pix_valid !== 1'b0) begin n_fail++; $display("FAIL al_stream got st %0d v %b exp 2/0", state, pix_valid); end
    drive(0, 1, 0, 32'h0, 0);
    n_tests++; if (pix_out !== 12'h234 || pix_valid !== 1'b1) begin n_fail++; $display("FAIL al_pixA got %h/%b exp 234/1", pix_out, pix_valid); end
    drive(0, 0, 0, 32'h0, 0);
    n_tests++; if (pix_out !== 12'h234 || pix_valid !== 1'b0) begin n_fail++; $display("FAIL al_hold got %h/%b exp 234/0", pix_out, pix_valid); end
    drive(0, 1, 0, 32'h0, 0);
    n_tests++; if (pix_out !== 12'h001 || pix_valid !== 1'b1 || fifo_level !== 5'd0) begin n_fail++; $display("FAIL al_pixB got %h/%b lvl %0d exp 001/1/0", pix_out, pix_valid, fifo_level); end
  endtask

  // Continues the frame above: pixels 3 and 4 arrive with the FIFO empty
  task automatic test_underflow;
    drive(0, 1, 0, 32'h0, 0);
    n_tests++; if (pix_out !== 12'h000 || pix_valid !== 1'b1 || underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set got %h/%b/%b exp 000/1/1", pix_out, pix_valid, underflow); end
    drive(0, 0, 0, 32'h0, 1);
    n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL uf_clr got %b exp 0", underflow); end
    drive(0, 1, 0, 32'h0, 1);
    n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL uf_setwins got %b exp 1", underflow); end
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL uf_frame_end got %0d exp 0", state); end
  endtask

  task automatic test_frame_end;
    drive(0, 0, 1, 32'h0122_2111, 0);
    drive(0, 0, 1, 32'h0044_4333, 0);
    drive(0, 0, 1, 32'h0166_6555, 0);
    n_tests++; if (state !== 2'd1 || fifo_level !== 5'd3) begin n_fail++; $display("FAIL fe_armed got st %0d lvl %0d exp 1/3", state, fifo_level); end
    drive(1, 1, 0, 32'h0, 0);
    n_tests++; if (state !== 2'd2 || pix_valid !== 1'b0) begin n_fail++; $display("FAIL fe_ignore got st %0d v %b exp 2/0", state, pix_valid); end
    drive(0, 1, 0, 32'h0, 0);
    n_tests++; if (pix_out !== 12'h111) begin n_fail++; $display("FAIL fe_p1 got %h exp 111", pix_out); end
    drive(0, 1, 0, 32'h0, 0);
    n_tests++; if (pix_out !== 12'h222) begin n_fail++; $display("FAIL fe_p2 got %h exp 222", pix_out); end
    drive(0, 1, 0, 32'h0, 0);
    n_tests++; if (pix_out !== 12'h333 || state !== 2'd2) begin n_fail++; $display("FAIL fe_p3 got %h st %0d exp 333/2", pix_out, state); end
    drive(0, 1, 0, 32'h0, 0);
    n_tests++; if (pix_out !== 12'h444 || state !== 2'd0 || fifo_level !== 5'd1) begin n_fail++; $display("FAIL fe_p4 got %h st %0d lvl %0d exp 444/0/1", pix_out, state, fifo_level); end
    drive(0, 0, 0, 32'h0, 0);
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL fe_rearm got %0d exp 1", state); end
  endtask

  task automatic test_resync;
    for (int k = 1; k <= 4; k++) drive(0, 0, 1, {8'h00, 12'hB00 + 12'(k), 12'hA00 + 12'(k)}, 0);
    n_tests++; if (fifo_level !== 5'd5) begin n_fail++; $display("FAIL rs_lvl got %0d exp 5", fifo_level); end
    drive(1, 0, 0, 32'h0, 0);
    drive(0, 1, 0, 32'h0, 0);
    n_tests++; if (pix_out !== 12'h555) begin n_fail++; $display("FAIL rs_p1 got %h exp 555", pix_out); end
    drive(0, 1, 1, 32'h00B0_5A05, 0);
    n_tests++; if (pix_out !== 12'h666 || fifo_level !== 5'd5) begin n_fail++; $display("FAIL rs_pushpop got %h lvl %0d exp 666/5", pix_out, fifo_level); end
    drive(1, 1, 0, 32'h0, 0);
    n_tests++; if (state !== 2'd0 || pix_valid !== 1'b0) begin n_fail++; $display("FAIL rs_seek got st %0d v %b exp 0/0", state, pix_valid); end
    drive(0, 0, 0, 32'h0, 0);
    n_tests++; if (fifo_level !== 5'd4) begin n_fail++; $display("FAIL rs_drop1 got %0d exp 4", fifo_level); end
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 32'h0, 0);
    n_tests++; if (fifo_level !== 5'd0 || state !== 2'd0) begin n_fail++; $display("FAIL rs_drain got lvl %0d st %0d exp 0/0", fifo_level, state); end
  endtask

  task automatic test_reset_mid_stream;
    drive(0, 0, 1, 32'h0100_0AAA, 0);
    for (int k = 1; k <= 7; k++) drive(0, 0, 1, 32'(k), 0);
    drive(1, 0, 0, 32'h0, 0);
    drive(0, 1, 0, 32'h0, 0);
    n_tests++; if (pix_out !== 12'hAAA) begin n_fail++; $display("FAIL rm_pA got %h exp aaa", pix_out); end
    drive(0, 1, 0, 32'h0, 0);
    n_tests++; if (state !== 2'd2 || fifo_level !== 5'd7 || pix_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre got st %0d lvl %0d v %b exp 2/7/1", state, fifo_level, pix_valid); end
    reset = 1'b1;
    nios_new_pix = 1'b0;
    #1;
    n_tests++; if (fifo_level !== 5'd0 || state !== 2'd0 || pix_valid !== 1'b0) begin n_fail++; $display("FAIL rm_async got lvl %0d st %0d v %b exp 0/0/0", fifo_level, state, pix_valid); end
    n_tests++; if (underflow !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rm_flags got %b%b exp 00", underflow, overflow); end
    @(negedge clk); @(negedge clk); reset = 1'b0;
    drive(0, 0, 0, 32'h0, 0);
    n_tests++; if (state !== 2'd0 || fifo_level !== 5'd0) begin n_fail++; $display("FAIL rm_after got st %0d lvl %0d exp 0/0", state, fifo_level); end
  endtask

  task automatic test_overflow;
    for (int k = 1; k <= 16; k++) begin
      drive(0, 0, 1, 32'h0100_0000 | 32'(k), 0);
      n_tests++; if (nios_ready !== (k < 12)) begin n_fail++; $display("FAIL of_ready lvl %0d got %b exp %b", k, nios_ready, (k < 12)); end
    end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL of_early got %b exp 0", overflow); end
    drive(0, 0, 1, 32'h0100_0011, 0);
    n_tests++; if (fifo_level !== 5'd16 || overflow !== 1'b1 || nios_ready !== 1'b0) begin n_fail++; $display("FAIL of_full got lvl %0d of %b rdy %b exp 16/1/0", fifo_level, overflow, nios_ready); end
    drive(0, 0, 1, 32'h0100_0012, 1);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL of_setwins got %b exp 1", overflow); end
    drive(0, 0, 0, 32'h0, 1);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL of_clr got %b exp 0", overflow); end
  endtask

  initial begin
    test_reset;
    test_align_stream;
    test_underflow;
    test_frame_end;
    test_resync;
    test_reset_mid_stream;
    test_overflow;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
